// File: rtl/dlatch_capture_stage.sv
// Captures a held D-latch word: Q/En are synchronised, and a word is offered only
// after En falls and Q stays equal for STABLE_CYCLES samples. One offer per En-low window.
module dlatch_capture_stage #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Q_in,
  input  logic             En_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] accept_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {TRACK, SETTLE, OFFER, WAIT_EN} state_t;

  localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] q_s1, q_s2;
  logic             en_s1, en_s2, en_s3;
  logic             fall;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] snapshot, snapshot_nxt;
  logic [3:0]       stab_cnt, stab_cnt_nxt;
  logic [WIDTH-1:0] data_r, data_nxt;
  logic             valid_r, valid_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             ovf_r, ovf_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_s1  <= '0;
      q_s2  <= '0;
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
      en_s3 <= 1'b0;
    end else begin
      q_s1  <= Q_in;
      q_s2  <= q_s1;
      en_s1 <= En_in;
      en_s2 <= en_s1;
      en_s3 <= en_s2;
    end
  end

  // en_s3 resets low, so a reset release with En already low never looks like a fall
  assign fall = en_s3 & ~en_s2;

  always_comb begin
    state_nxt    = state;
    snapshot_nxt = snapshot;
    stab_cnt_nxt = stab_cnt;
    data_nxt     = data_r;
    valid_nxt    = valid_r;
    cnt_nxt      = cnt_r;
    ovf_nxt      = ovf_r;
    unique case (state)
      TRACK: begin
        if (fall) begin
          snapshot_nxt = q_s2;
          stab_cnt_nxt = 4'd1;
          if (STABLE_CYCLES == 1) begin
            data_nxt  = q_s2;
            valid_nxt = 1'b1;
            state_nxt = OFFER;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (en_s2) begin
          state_nxt = TRACK;
        end else if (q_s2 != snapshot) begin
          snapshot_nxt = q_s2;
          stab_cnt_nxt = 4'd1;
        end else if (stab_cnt == STAB_LAST) begin
          data_nxt  = snapshot;
          valid_nxt = 1'b1;
          state_nxt = OFFER;
        end else begin
          stab_cnt_nxt = stab_cnt + 4'd1;
        end
      end
      OFFER: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          if (cnt_r != '1) cnt_nxt = cnt_r + 1'b1;
          state_nxt = en_s2 ? TRACK : WAIT_EN;
        end else if (fall) begin
          // new window arrives while the old word is unread: drop it, remember the loss
          ovf_nxt = 1'b1;
        end
      end
      WAIT_EN: begin
        if (en_s2) state_nxt = TRACK;
      end
      default: state_nxt = TRACK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TRACK;
      snapshot <= '0;
      stab_cnt <= '0;
      data_r   <= '0;
      valid_r  <= 1'b0;
      cnt_r    <= '0;
      ovf_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      snapshot <= snapshot_nxt;
      stab_cnt <= stab_cnt_nxt;
      data_r   <= data_nxt;
      valid_r  <= valid_nxt;
      cnt_r    <= cnt_nxt;
      ovf_r    <= ovf_nxt;
    end
  end

  assign out_data   = data_r;
  assign out_valid  = valid_r;
  assign accept_cnt = cnt_r;
  assign overflow   = ovf_r;

endmodule

// File: doc/dlatch_capture_stage.md
Name: dlatch_capture_stage

Overview:
- Downstream consumer of the 4-bit D latch.
- Takes the latch's Q and En, both asynchronous to clk, and synchronises them into one clock domain.
- Accepts a held latch value only after En has fallen and Q has stayed stable for a set number of cycles.
- Offers each accepted word once per En-low window on a valid/ready output, with an accept counter and a sticky overflow flag.

Parameters:
- WIDTH, 4, width of latch data Q_in / out_data.
- STABLE_CYCLES, 3, consecutive equal synchronised samples required before acceptance; legal range 1..15.
- CNT_W, 8, width of the accept counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Q_in  input  WIDTH  latch output Q, asynchronous.
- En_in  input  1  latch enable En, asynchronous; 1 = transparent, 0 = holding.
- out_data  output  WIDTH  accepted latch value.
- out_valid  output  1  out_data is offered.
- out_ready  input  1  consumer accepts out_data this cycle.
- accept_cnt  output  CNT_W  number of completed handshakes, saturating.
- overflow  output  1  sticky: an En-low window was dropped while a word was still unread.

Behaviour:
- Reset (async, rst=1):
  - Sync flops q_s1, q_s2, en_s1, en_s2, en_s3 = 0.
  - State TRACK; snapshot = 0; stab_cnt = 0.
  - out_data = 0, out_valid = 0, accept_cnt = 0, overflow = 0.
  - Asserting reset mid-operation aborts any pending offer with no handshake counted.
- Synchronisation:
  - Q_in and En_in each pass through 2 flops (q_s2, en_s2); en_s3 is en_s2 delayed by one cycle.
  - Falling-edge detect fall = en_s3 & ~en_s2. Because en_s3 resets to 0, no spurious edge occurs after reset.
- FSM states: TRACK, SETTLE, OFFER, WAIT_EN.
  - TRACK:
    - q_s2 is ignored; X or changing data while En=1 must never reach out_data.
    - On fall: snapshot <= q_s2, stab_cnt <= 1.
    - If STABLE_CYCLES == 1, go directly to OFFER, loading out_data <= q_s2 and setting out_valid.
    - Otherwise go to SETTLE.
  - SETTLE:
    - en_s2 = 1: abort to TRACK, no output.
    - q_s2 != snapshot: snapshot <= q_s2, stab_cnt <= 1.
    - q_s2 == snapshot and stab_cnt == STABLE_CYCLES-1: out_data <= snapshot, out_valid <= 1, go to OFFER.
    - Otherwise stab_cnt increments.
  - OFFER:
    - out_valid = 1; out_data is held constant.
    - If out_ready = 1: handshake completes this cycle. Next cycle out_valid = 0 and accept_cnt increments (saturates at all-ones). Go to WAIT_EN if en_s2 = 0, else TRACK.
    - If a fall occurs in OFFER without a handshake that cycle: overflow <= 1. The new window is dropped and the current word stays offered.
    - If fall and out_ready coincide: the handshake completes, overflow is not set, and the FSM goes to WAIT_EN.
  - WAIT_EN: stay until en_s2 = 1, then go to TRACK. This enforces one capture per En-low window.
- Latency:
  - Edge 1 is the first rising edge sampling En_in = 0, with Q_in already stable.
  - out_valid rises after edge 2+STABLE_CYCLES; with the default that is edge 5.
  - out_valid falls one cycle after the out_ready handshake.
- out_data keeps its last value after out_valid drops. Only a load from SETTLE/TRACK changes it.

Test Plan:
- Reset then default params: Q_in = 4'hF, En_in = 1 for 5 cycles, then En_in = 0, out_ready = 0 -> out_valid = 1 after edge 5, out_data = 4'hF; out_valid and out_data are held until out_ready. out_ready = 1 for one cycle -> out_valid = 0 next cycle, accept_cnt = 1.
- Q_in = 4'hx with En_in = 1, then Q_in = 4'h7 and En_in = 0 on the same edge -> out_data = 4'h7, never X. Bench checks out_data is not X from reset onward.
- En_in low; Q_in = 4'h2 for 1 cycle, then changes to 4'hD (bits 3..0 = 1101) -> restabilisation; out_data = 4'hD, offered 3 stable cycles after the change.
- En_in low for 2 cycles, then high again before stability -> no out_valid; FSM returns to TRACK; accept_cnt unchanged.
- Word 4'hE offered, out_ready = 0; En_in toggles 1 -> 0 with Q_in = 4'h1 -> overflow = 1 and sticky. out_data stays 4'hE until accepted, and 4'h1 is never offered.
- Assert rst while out_valid = 1 -> all outputs 0 immediately (async). After release, En_in held low with no fall -> no capture.
